// File: rtl/muldiv.sv
// muldiv -- multi-cycle RV32M multiply/divide unit.
//
// Multiplies use iterative shift-add and divides use iterative restoring
// subtraction. Both work on operand magnitudes. A final FIX cycle applies the
// sign correction and selects the result half. Divide-by-zero and signed
// overflow bypass the iteration and complete in one cycle.
//
// Optional build macro: MULDIV_FAST_MUL_EN
//   When defined, all multiplies use a combinational multiplier and complete
//   in one cycle. Divides are unaffected.
//
// Ports:
//   clk    clock, rising edge
//   rst    synchronous reset, active-high
//   start  request valid, accepted when ready=1
//   op     RV32M funct3 (MUL..REMU)
//   rs1    operand A (multiplicand / dividend)
//   rs2    operand B (multiplier / divisor)
//   ready  idle, can accept start
//   busy   operation in flight (~ready)
//   done   one-cycle pulse, rd/flags valid
//   rd     result, held until the next op completes
//   flags  {N, Z, C(div by zero), V(signed div overflow)}
module muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            ready,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] rd,
   output logic [3:0]      flags
);

   localparam int W2 = 2 * XLEN;
   localparam int CW = $clog2(XLEN + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t            state_reg, state_next;
   logic [2:0]        op_reg;
   logic              neg_reg;
   logic [XLEN-1:0]   m_reg;      // multiplicand (mul) or divisor (div) magnitude
   logic [W2-1:0]     p_reg;      // {acc, multiplier} or {remainder, quotient}
   logic [CW-1:0]     cnt_reg;
   logic [XLEN-1:0]   rd_reg;
   logic [3:0]        flags_reg;

   // Sign correction and half selection shared by the FIX cycle and the
   // single-cycle multiply path.
   function automatic logic [XLEN-1:0] fix_res(input logic [2:0] f_op,
                                               input logic f_neg,
                                               input logic [W2-1:0] f_p);
      logic [W2-1:0]   full;
      logic [XLEN-1:0] half;
      if (!f_op[2]) begin
         full = f_neg ? -f_p : f_p;
         fix_res = (f_op == 3'b000) ? full[XLEN-1:0] : full[W2-1:XLEN];
      end else begin
         half = f_op[1] ? f_p[W2-1:XLEN] : f_p[XLEN-1:0];
         fix_res = f_neg ? -half : half;
      end
   endfunction

   // Input decode
   logic            a_signed, b_signed, sa, sb, neg_in, dz, ovf, direct;
   logic [XLEN-1:0] a_mag, b_mag, special_rd, direct_rd;

   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (op)
         3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
         3'b010:                         a_signed = 1'b1;
         default: ;
      endcase
   end

   assign sa     = a_signed & rs1[XLEN-1];
   assign sb     = b_signed & rs2[XLEN-1];
   assign a_mag  = sa ? -rs1 : rs1;
   assign b_mag  = sb ? -rs2 : rs2;
   // Remainder takes the dividend's sign; everything else takes the XOR.
   assign neg_in = (op[2] && op[1]) ? sa : (sa ^ sb);
   assign dz     = op[2] && (rs2 == '0);
   assign ovf    = op[2] && !op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
   assign special_rd = dz  ? (op[1] ? rs1 : '1) :
                            (op[1] ? '0  : {1'b1, {(XLEN-1){1'b0}}});

`ifdef MULDIV_FAST_MUL_EN
   logic [W2-1:0] fast_p;
   assign fast_p    = W2'(a_mag) * W2'(b_mag);
   assign direct    = dz | ovf | !op[2];
   assign direct_rd = (dz | ovf) ? special_rd : fix_res(op, neg_in, fast_p);
`else
   assign direct    = dz | ovf;
   assign direct_rd = special_rd;
`endif

   // One iteration step
   logic [XLEN:0]   mul_sum, rem_sh, diff;
   logic [W2-1:0]   mul_p, div_p, step_p;
   logic [XLEN-1:0] fix_rd;

   assign mul_sum = {1'b0, p_reg[W2-1:XLEN]} + (p_reg[0] ? {1'b0, m_reg} : '0);
   assign mul_p   = {mul_sum, p_reg[XLEN-1:1]};
   assign rem_sh  = {p_reg[W2-1:XLEN], p_reg[XLEN-1]};
   assign diff    = rem_sh - {1'b0, m_reg};
   // Negative trial difference means restore: keep the shifted remainder.
   assign div_p   = diff[XLEN] ? {rem_sh[XLEN-1:0], p_reg[XLEN-2:0], 1'b0}
                               : {diff[XLEN-1:0],   p_reg[XLEN-2:0], 1'b1};
   assign step_p  = op_reg[2] ? div_p : mul_p;
   assign fix_rd  = fix_res(op_reg, neg_reg, p_reg);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start) state_next = direct ? DONE : RUN;
         RUN:  if (cnt_reg == CW'(1)) state_next = FIX;
         FIX:  state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         op_reg    <= '0;
         neg_reg   <= 1'b0;
         m_reg     <= '0;
         p_reg     <= '0;
         cnt_reg   <= '0;
         rd_reg    <= '0;
         flags_reg <= 4'b0100;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: if (start) begin
               op_reg  <= op;
               neg_reg <= neg_in;
               m_reg   <= op[2] ? b_mag : a_mag;
               p_reg   <= {{XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
               cnt_reg <= CW'(XLEN);
               if (direct) begin
                  rd_reg    <= direct_rd;
                  flags_reg <= {direct_rd[XLEN-1], direct_rd == '0, dz, ovf};
               end
            end
            RUN: begin
               p_reg   <= step_p;
               cnt_reg <= cnt_reg - CW'(1);
            end
            FIX: begin
               rd_reg    <= fix_rd;
               flags_reg <= {fix_rd[XLEN-1], fix_rd == '0, 2'b00};
            end
            default: ;
         endcase
      end
   end

   assign ready = (state_reg == IDLE);
   assign busy  = !ready;
   assign done  = (state_reg == DONE);
   assign rd    = rd_reg;
   assign flags = flags_reg;

endmodule

// File: tb/tb_muldiv.sv
module tb_muldiv;
   logic        clk = 1'b0;
   logic        rst, start;
   logic [2:0]  op;
   logic [31:0] rs1, rs2;
   logic        ready, busy, done;
   logic [31:0] rd;
   logic [3:0]  flags;

   int checks = 0;
   int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 34;
`endif

   always #5 clk = ~clk;

   muldiv dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
      .ready(ready), .busy(busy), .done(done), .rd(rd), .flags(flags)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op, scramble the inputs right after acceptance, wait for done.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_rd,
                         input logic [3:0] exp_fl, input int exp_lat);
      int lat, rdy_hi, guard;
      guard = 0;
      while (ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
      op = o; rs1 = a; rs2 = b; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
      lat = 0; rdy_hi = 0;
      do begin
         @(negedge clk);
         lat++;
         if (ready !== 1'b0 || busy !== 1'b1) rdy_hi++;
      end while (done !== 1'b1 && lat < 100);
      if (done !== 1'b1) lat = 999;
      $display("%s op=%0d rs1=%h rs2=%h rd=%h flags=%b latency=%0d", tag, o, a, b, rd, flags, lat);
      chk({tag, "_lat"},   lat,    exp_lat);
      chk({tag, "_rd"},    rd,     exp_rd);
      chk({tag, "_flags"}, {28'd0, flags}, {28'd0, exp_fl});
      chk({tag, "_busy"},  rdy_hi, 0);
      @(negedge clk);
   endtask

   initial begin
      int lat, ndone;
      rst = 1'b1; start = 1'b0; op = '0; rs1 = '0; rs2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 1);
      chk("rst_busy",  {31'd0, busy},  0);
      chk("rst_done",  {31'd0, done},  0);
      chk("rst_rd",    rd, 0);
      chk("rst_flags", {28'd0, flags}, 32'h4);
      rst = 1'b0;
      @(negedge clk);

      run_op("mul",      3'b000, 32'd20,       32'd30,       32'd600,      4'b0000, MUL_LAT);
      run_op("mul_neg",  3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 4'b1000, MUL_LAT);
      run_op("mulh",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 4'b0000, MUL_LAT);
      run_op("mulhu",    3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 4'b0000, MUL_LAT);
      run_op("mulhu_ff", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1000, MUL_LAT);
      run_op("mulhsu",   3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 4'b1000, MUL_LAT);
      run_op("divu_z",   3'b101, 32'd7,        32'd0,        32'hFFFFFFFF, 4'b1010, 1);
      run_op("remu_z",   3'b111, 32'd7,        32'd0,        32'd7,        4'b0010, 1);
      run_op("div_z",    3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 4'b1010, 1);
      run_op("rem_z",    3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 4'b1010, 1);
      run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b1001, 1);
      run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        4'b0101, 1);
      run_op("rem_n7_2", 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 4'b1000, 34);
      run_op("div_n7_2", 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 4'b1000, 34);
      run_op("div_7_n2", 3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 4'b1000, 34);
      run_op("rem_7_n2", 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        4'b0000, 34);
      run_op("divu",     3'b101, 32'd100,      32'd7,        32'd14,       4'b0000, 34);

      // Abort mid-operation with rst while start is held high.
      op = 3'b101; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
      @(posedge clk);
      ndone = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_nodone",    ndone, 0);
      chk("abort_ready",     {31'd0, ready}, 1);
      chk("abort_done_low",  {31'd0, done},  0);
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (done !== 1'b1 && lat < 100);
      if (done !== 1'b1) lat = 999;
      start = 1'b0;
      $display("abort_retry op=5 rs1=00000064 rs2=00000007 rd=%h flags=%b latency=%0d", rd, flags, lat);
      chk("retry_lat", lat, 34);
      chk("retry_rd",  rd,  32'd14);
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      chk("retry_single", ndone, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
